sdp_ram_banked_dualclk_ne: RTL
==============================

# sdp_ram_banked_dualclk_ne

Banked simple dual-port RAM for the decoder message store: independent write (wrclk) and read (rdclk) clocks, NBANKS lanes of WIDTH bits sharing one address, per-bank write enables, a configurable read pipeline with valid flag, and an optional zero-fill sweep after reset. It is the next generation of the decoder's single-lane dual-clock RAM. Check-node/variable-node units write through the wrclk port and the layer scheduler reads through rdclk.

## Interface
- WIDTH, 6, bits per bank word
- ADDRESSWIDTH, 9, address bits
- MEMDEPTH, 512, words per bank (≤ 2^ADDRESSWIDTH)
- NBANKS, 4, number of parallel banks
- RD_LAT, 1, read latency in rdclk cycles (legal values 1..4)
- CLR_ON_RESET, 1, 1 = zero-fill all words after reset release
- rdclk  in  1  read clock
- rst  in  1  reset, synchronous, active-low; sampled on rdclk in the read domain and on wrclk in the write domain
- wrclk  in  1  write clock
- RA  in  ADDRESSWIDTH  read address
- rd_in  in  1  read request
- DOUT  out  NBANKS*WIDTH  read data; bank b in bits [b*WIDTH +: WIDTH]
- dout_valid  out  1  DOUT carries a read result
- mem_ready  out  1  rdclk-domain: clear sweep done
- WA  in  ADDRESSWIDTH  write address
- wr_in  in  1  write request
- wr_be  in  NBANKS  per-bank write enable
- DIN  in  NBANKS*WIDTH  write data, same packing as DOUT
- wr_busy  out  1  wrclk-domain: reset or sweep in progress, writes dropped
- parity_err  out  NBANKS  sticky per-bank parity error (present only with RAM_PARITY_EN)

## Operation
- Write FSM (wrclk): states CLEAR, IDLE. rst low → CLEAR, clr_addr=0, wr_busy=1, no array writes.
- CLEAR with rst high: each edge writes 0 to every bank at clr_addr and increments clr_addr; the write at MEMDEPTH-1 moves the FSM to IDLE, and wr_busy=0 from the next edge. If CLR_ON_RESET=0, the FSM goes from CLEAR to IDLE on the first edge with rst high, with no writes.
- IDLE: wr_in=1 and WA<MEMDEPTH → bank b is written with DIN slice b when wr_be[b]=1; other banks are unchanged. wr_in during CLEAR is dropped, not queued. WA≥MEMDEPTH: write ignored.
- Reset does not clear array contents except through the sweep.
- Read pipe (rdclk): stage 0 registers rd_in ? mem[RA] : 0 and valid=rd_in; stages 1..RD_LAT-1 shift data and valid. DOUT/dout_valid are the last stage. RA≥MEMDEPTH with rd_in=1 → DOUT=0, dout_valid=1.
- mem_ready: 2-flop synchronizer of !wr_busy into rdclk; reset value 0.
- Reads before mem_ready=1 are legal, but their data is undefined.

## Timing
- Reset values: DOUT=0, dout_valid=0, all pipe stages 0, mem_ready=0, wr_busy=1, parity_err=0.
- Read latency: rd_in sampled at rdclk edge N → DOUT/dout_valid updated at edge N+RD_LAT-1 and visible after it (RD_LAT=1 matches the legacy single-register read).
- Back-to-back reads are accepted every cycle. Throughput is 1 read per rdclk, 1 write per wrclk.
- Sweep length: exactly MEMDEPTH wrclk cycles of wr_busy=1 after rst rises. mem_ready rises 2–3 rdclk edges after wr_busy falls.
- rst low mid-sweep restarts the sweep from address 0. rst low mid-read flushes the pipe; in-flight results are lost.
- Same-address read and write on unrelated edges returns old or new data, unspecified. With a common clock, read-during-write returns old data.
- rst must be held low ≥2 cycles of the slower clock.

## Configuration
- RAM_PARITY_EN defined: each bank word stores an extra even-parity bit (XOR of the data), written with data and by the sweep. On a read with valid=1, a mismatch on bank b sets parity_err[b] in the same cycle dout_valid is asserted. The bit stays set until reset. Out-of-range reads never flag.
- RAM_PARITY_EN undefined: no parity storage, parity_err port absent, array width is WIDTH per bank.

## Test plan
- Reset release, CLR_ON_RESET=1, MEMDEPTH=512 → wr_busy=1 for exactly 512 wrclk cycles; mem_ready=1 within 3 rdclk cycles after; read of every address → DOUT=0, dout_valid=1.
- Write WA=5, DIN=all banks 6'h2A, wr_be=4'b0101, after a prior write of 6'h15 to all banks → read RA=5 returns banks 0,2 =6'h2A and banks 1,3 =6'h15.
- RD_LAT=3, rd_in pulses at edges 10,11,13 → dout_valid high at edges 12,13,15. DOUT=0 and dout_valid=0 at edge 14.
- Assert wr_in during sweep cycle 100 with WA=7, DIN=6'h3F → after mem_ready, RA=7 reads 0. Pulse rst low at sweep cycle 300 → wr_busy stays high for a full 512 cycles after re-release.
- RA=MEMDEPTH (512, ADDRESSWIDTH=10) with rd_in=1 → DOUT=0, dout_valid=1. WA=600 write → no array change.
- RAM_PARITY_EN: force-flip one stored data bit of bank 2 at address 9, then read RA=9 → parity_err=4'b0100 aligned with dout_valid and held until rst.

Source files
------------

// File: rtl/sdp_ram_banked_dualclk_ne.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_banked_dualclk_ne
// Purpose  : Banked simple dual-port RAM for the decoder message store.
//            NBANKS lanes of WIDTH bits share one address. The write port
//            (wrclk) has per-bank enables. The read port (rdclk) has an
//            RD_LAT-deep pipeline with a valid flag. An optional zero-fill
//            sweep runs after reset.
// Ports    : rdclk, rst (sync, active-low, sampled in each clock domain), wrclk
//            RA, rd_in            -> DOUT, dout_valid (read domain)
//            mem_ready            : sweep finished, synchronized into rdclk
//            WA, wr_in, wr_be, DIN (write domain), wr_busy (writes dropped)
//            parity_err           : sticky per-bank parity error
// Options  : define RAM_PARITY_EN to store an even-parity bit per bank word
//            and expose parity_err.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram_banked_dualclk_ne #(
    parameter int WIDTH        = 6,
    parameter int ADDRESSWIDTH = 9,
    parameter int MEMDEPTH     = 512,
    parameter int NBANKS       = 4,
    parameter int RD_LAT       = 1,
    parameter int CLR_ON_RESET = 1
) (
    input  logic                       rdclk,
    input  logic                       rst,
    input  logic                       wrclk,
    input  logic [ADDRESSWIDTH-1:0]    RA,
    input  logic                       rd_in,
    output logic [NBANKS*WIDTH-1:0]    DOUT,
    output logic                       dout_valid,
    output logic                       mem_ready,
`ifdef RAM_PARITY_EN
    output logic [NBANKS-1:0]          parity_err,
`endif
    input  logic [ADDRESSWIDTH-1:0]    WA,
    input  logic                       wr_in,
    input  logic [NBANKS-1:0]          wr_be,
    input  logic [NBANKS*WIDTH-1:0]    DIN,
    output logic                       wr_busy
);

    localparam int c_IDXW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
`ifdef RAM_PARITY_EN
    localparam int c_SW = WIDTH + 1;   // stored word: {parity, data}
`else
    localparam int c_SW = WIDTH;
`endif
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(MEMDEPTH - 1);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic [0:0]              r_state;
    logic [0:0]              w_state_next;
    logic [c_IDXW-1:0]       r_clr_addr;
    logic [NBANKS-1:0]       w_we;
    logic [c_IDXW-1:0]       w_waddr;
    logic [NBANKS*WIDTH-1:0] w_wdata;
    logic                    w_wr_ok;

    // Widened compare so the check stays meaningful when MEMDEPTH == 2^AW.
    assign w_wr_ok = (32'(WA) < MEMDEPTH);

    always_ff @(posedge wrclk) begin
        if (!rst) begin
            r_state    <= c_ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_CLEAR: begin
                if ((CLR_ON_RESET == 0) || (r_clr_addr == c_LAST)) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_IDLE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_CLEAR;
        endcase
    end

    // rst gates every array write so the reset edge itself never writes.
    always_comb begin
        wr_busy = (r_state == c_ST_CLEAR);
        w_we    = '0;
        w_waddr = r_clr_addr;
        w_wdata = '0;
        if (r_state == c_ST_CLEAR) begin
            if ((CLR_ON_RESET != 0) && rst) begin
                w_we = '1;
            end
        end else if (rst && wr_in && w_wr_ok) begin
            w_we    = wr_be;
            w_waddr = WA[c_IDXW-1:0];
            w_wdata = DIN;
        end
    end

    // ------------------------------------------------------------------
    // Storage banks and read stage 0 inputs
    // ------------------------------------------------------------------
    logic                    w_rd_ok;
    logic [c_IDXW-1:0]       w_ridx;
    logic [NBANKS*WIDTH-1:0] w_rd_data0;
`ifdef RAM_PARITY_EN
    logic [NBANKS-1:0]       w_perr0;
`endif

    assign w_rd_ok = rd_in && (32'(RA) < MEMDEPTH);
    assign w_ridx  = RA[c_IDXW-1:0];

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [c_SW-1:0]  r_mem [MEMDEPTH];
        logic [WIDTH-1:0] w_wslice;
        logic [c_SW-1:0]  w_wword;
        logic [c_SW-1:0]  w_rword;

        assign w_wslice = w_wdata[b*WIDTH +: WIDTH];
`ifdef RAM_PARITY_EN
        assign w_wword  = {^w_wslice, w_wslice};
`else
        assign w_wword  = w_wslice;
`endif

        always_ff @(posedge wrclk) begin
            if (w_we[b]) begin
                r_mem[w_waddr] <= w_wword;
            end
        end

        assign w_rword = r_mem[w_ridx];
        assign w_rd_data0[b*WIDTH +: WIDTH] = w_rd_ok ? w_rword[WIDTH-1:0] : '0;
`ifdef RAM_PARITY_EN
        // Whole stored word XORs to 1 when data and parity disagree.
        assign w_perr0[b] = w_rd_ok & (^w_rword);
`endif
    end

    // ------------------------------------------------------------------
    // Read pipeline (rdclk)
    // ------------------------------------------------------------------
    logic [NBANKS*WIDTH-1:0] r_pipe_data [RD_LAT];
    logic [RD_LAT-1:0]       r_pipe_valid;
`ifdef RAM_PARITY_EN
    logic [NBANKS-1:0]       r_pipe_err [RD_LAT];
    logic [NBANKS-1:0]       r_perr_sticky;
`endif

    always_ff @(posedge rdclk) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_data[i] <= '0;
`ifdef RAM_PARITY_EN
                r_pipe_err[i]  <= '0;
`endif
            end
            r_pipe_valid <= '0;
        end else begin
            r_pipe_data[0]  <= w_rd_data0;
            r_pipe_valid[0] <= rd_in;
`ifdef RAM_PARITY_EN
            r_pipe_err[0]   <= w_perr0;
`endif
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_data[i]  <= r_pipe_data[i-1];
                r_pipe_valid[i] <= r_pipe_valid[i-1];
`ifdef RAM_PARITY_EN
                r_pipe_err[i]   <= r_pipe_err[i-1];
`endif
            end
        end
    end

    assign DOUT       = r_pipe_data[RD_LAT-1];
    assign dout_valid = r_pipe_valid[RD_LAT-1];

`ifdef RAM_PARITY_EN
    // The last-stage error flag shows up with dout_valid; the sticky
    // register keeps it afterwards until reset.
    always_ff @(posedge rdclk) begin
        if (!rst) begin
            r_perr_sticky <= '0;
        end else begin
            r_perr_sticky <= r_perr_sticky | r_pipe_err[RD_LAT-1];
        end
    end

    assign parity_err = r_perr_sticky | r_pipe_err[RD_LAT-1];
`endif

    // ------------------------------------------------------------------
    // Sweep-done synchronizer into rdclk
    // ------------------------------------------------------------------
    logic r_rdy_meta;
    logic r_rdy_sync;

    always_ff @(posedge rdclk) begin
        if (!rst) begin
            r_rdy_meta <= 1'b0;
            r_rdy_sync <= 1'b0;
        end else begin
            r_rdy_meta <= !wr_busy;
            r_rdy_sync <= r_rdy_meta;
        end
    end

    assign mem_ready = r_rdy_sync;

endmodule
`default_nettype wire
